alu_exec_unit: RTL and testbench

Integer execution unit that sits on the dispatch end of the reservation station. It accepts one ready instruction per cycle on the `rs_to_alu_*` bus and computes a 32-bit result. Results are buffered in a small FIFO and broadcast on the common data bus (`alu_to_rs_*`) under a grant handshake, so the reservation station and ROB can wake dependents and mark entries done.

---
 rtl/alu_exec_unit.sv | 216 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execution unit with a result FIFO feeding the CDB.
// Dispatch lands in stage register S, then is pushed into a circular FIFO
// whose head is broadcast under the CDB grant handshake.
// Optional feature macro: ALU_MUL_EN enables a 4-cycle iterative multiply on
// function 13. When the macro is undefined, function 13 returns 0 in a single cycle.
module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W      = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clr_in,
    input  logic             rs_to_alu_ready,
    input  logic [4:0]       rs_to_alu_op,
    input  logic [31:0]      rs_to_alu_rs1,
    input  logic [31:0]      rs_to_alu_rs2,
    input  logic [31:0]      rs_to_alu_imm,
    input  logic [31:0]      rs_to_alu_PC,
    input  logic [ROB_W-1:0] rs_to_alu_rob_index,
    output logic             alu_full_out,
    output logic             alu_to_rs_ready,
    output logic [31:0]      alu_to_rs_result,
    output logic [ROB_W-1:0] alu_to_rs_rob_index,
    input  logic             cdb_grant_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    // Stage register S
    logic             s_valid;
    logic [31:0]      s_result;
    logic [ROB_W-1:0] s_rob;

    // Result FIFO
    logic [31:0]      fifo_result [FIFO_DEPTH];
    logic [ROB_W-1:0] fifo_rob    [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Multiplier interface (tied off when the multiply is not built)
    logic             mul_busy;
    logic             mul_start;
    logic             mul_push;
    logic [31:0]      mul_sum;
    logic [ROB_W-1:0] mul_rob;

    logic [31:0]      op_b;
    logic [31:0]      alu_res;
    logic [OCC_W-1:0] occupancy;
    logic             accept;
    logic             s_load;
    logic             pop;
    logic             fifo_space;
    logic             s_push;
    logic             push;
    logic [31:0]      push_result;
    logic [ROB_W-1:0] push_rob;

    assign op_b = rs_to_alu_op[4] ? rs_to_alu_imm : rs_to_alu_rs2;

    // Single-cycle function decode on the dispatch bus
    always_comb begin
        alu_res = '0;
        case (rs_to_alu_op[3:0])
            4'd0:  alu_res = rs_to_alu_rs1 + op_b;
            4'd1:  alu_res = rs_to_alu_rs1 - op_b;
            4'd2:  alu_res = rs_to_alu_rs1 & op_b;
            4'd3:  alu_res = rs_to_alu_rs1 | op_b;
            4'd4:  alu_res = rs_to_alu_rs1 ^ op_b;
            4'd5:  alu_res = rs_to_alu_rs1 << op_b[4:0];
            4'd6:  alu_res = rs_to_alu_rs1 >> op_b[4:0];
            4'd7:  alu_res = $signed(rs_to_alu_rs1) >>> op_b[4:0];
            4'd8:  alu_res = {31'd0, $signed(rs_to_alu_rs1) < $signed(op_b)};
            4'd9:  alu_res = {31'd0, rs_to_alu_rs1 < op_b};
            4'd10: alu_res = rs_to_alu_imm;
            4'd11: alu_res = rs_to_alu_PC + rs_to_alu_imm;
            4'd12: alu_res = rs_to_alu_PC + 32'd4;
            default: alu_res = '0;
        endcase
    end

    // Full counts everything already committed to a FIFO slot
    assign occupancy    = OCC_W'(count) + OCC_W'(s_valid) + OCC_W'(mul_busy);
    assign alu_full_out = mul_busy || (occupancy >= OCC_W'(FIFO_DEPTH));

    assign accept     = rs_to_alu_ready && !alu_full_out && rdy_in;
    assign s_load     = accept && !mul_start;
    assign pop        = rdy_in && cdb_grant_in && (count != '0);
    // A full FIFO still accepts a push when the head pops on the same edge
    assign fifo_space = (count < CNT_W'(FIFO_DEPTH)) || pop;
    assign s_push     = s_valid && rdy_in && fifo_space;
    // S and the multiplier are never valid together, so a plain OR is safe
    assign push        = s_push || mul_push;
    assign push_result = mul_push ? mul_sum : s_result;
    assign push_rob    = mul_push ? mul_rob : s_rob;

`ifdef ALU_MUL_EN
    logic [1:0]  mul_cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_acc;

    assign mul_start = accept && (rs_to_alu_op[3:0] == 4'd13);
    // One byte of B per cycle; A is pre-shifted so partial products just add
    assign mul_sum   = mul_acc + (mul_a * {24'd0, mul_b[7:0]});
    assign mul_push  = mul_busy && (mul_cnt == 2'd3) && rdy_in && fifo_space;

    // Iterative multiply: three accumulate steps, the fourth pushes the sum
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mul_busy <= 1'b0;
            mul_cnt  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_acc  <= '0;
            mul_rob  <= '0;
        end else if (clr_in) begin
            mul_busy <= 1'b0;
            mul_cnt  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_acc  <= '0;
            mul_rob  <= '0;
        end else if (rdy_in) begin
            if (mul_start) begin
                mul_busy <= 1'b1;
                mul_cnt  <= '0;
                mul_a    <= rs_to_alu_rs1;
                mul_b    <= op_b;
                mul_acc  <= '0;
                mul_rob  <= rs_to_alu_rob_index;
            end else if (mul_busy) begin
                if (mul_cnt != 2'd3) begin
                    mul_cnt <= mul_cnt + 2'd1;
                    mul_a   <= mul_a << 8;
                    mul_b   <= mul_b >> 8;
                    mul_acc <= mul_sum;
                end else if (mul_push) begin
                    mul_busy <= 1'b0;
                end
            end
        end
    end
`else
    assign mul_busy  = 1'b0;
    assign mul_start = 1'b0;
    assign mul_push  = 1'b0;
    assign mul_sum   = '0;
    assign mul_rob   = '0;
`endif

    // Stage register S: holds one computed result until the FIFO takes it
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s_valid  <= 1'b0;
            s_result <= '0;
            s_rob    <= '0;
        end else if (clr_in) begin
            s_valid  <= 1'b0;
            s_result <= '0;
            s_rob    <= '0;
        end else if (rdy_in) begin
            if (s_load) begin
                s_valid  <= 1'b1;
                s_result <= alu_res;
                s_rob    <= rs_to_alu_rob_index;
            end else if (s_push) begin
                s_valid <= 1'b0;
            end
        end
    end

    // Circular result FIFO; storage is cleared so the idle head reads zero
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_result[i] <= '0;
                fifo_rob[i]    <= '0;
            end
        end else if (clr_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_result[i] <= '0;
                fifo_rob[i]    <= '0;
            end
        end else if (rdy_in) begin
            if (push) begin
                fifo_result[tail] <= push_result;
                fifo_rob[tail]    <= push_rob;
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign alu_to_rs_ready     = (count != '0);
    assign alu_to_rs_result    = fifo_result[head];
    assign alu_to_rs_rob_index = fifo_rob[head];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed latency/boundary cases plus
// randomized traffic checked against an in-order scoreboard model.
module tb_alu_exec_unit;

    localparam int DEPTH = 4;
    localparam int RW    = 4;
`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clr_in;
    logic          rs_to_alu_ready;
    logic [4:0]    rs_to_alu_op;
    logic [31:0]   rs_to_alu_rs1;
    logic [31:0]   rs_to_alu_rs2;
    logic [31:0]   rs_to_alu_imm;
    logic [31:0]   rs_to_alu_PC;
    logic [RW-1:0] rs_to_alu_rob_index;
    logic          alu_full_out;
    logic          alu_to_rs_ready;
    logic [31:0]   alu_to_rs_result;
    logic [RW-1:0] alu_to_rs_rob_index;
    logic          cdb_grant_in;

    typedef struct packed {
        logic [31:0]   result;
        logic [RW-1:0] rob;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_in = ~clk_in;

    alu_exec_unit #(
        .FIFO_DEPTH(DEPTH),
        .ROB_W     (RW)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .clr_in             (clr_in),
        .rs_to_alu_ready    (rs_to_alu_ready),
        .rs_to_alu_op       (rs_to_alu_op),
        .rs_to_alu_rs1      (rs_to_alu_rs1),
        .rs_to_alu_rs2      (rs_to_alu_rs2),
        .rs_to_alu_imm      (rs_to_alu_imm),
        .rs_to_alu_PC       (rs_to_alu_PC),
        .rs_to_alu_rob_index(rs_to_alu_rob_index),
        .alu_full_out       (alu_full_out),
        .alu_to_rs_ready    (alu_to_rs_ready),
        .alu_to_rs_result   (alu_to_rs_result),
        .alu_to_rs_rob_index(alu_to_rs_rob_index),
        .cdb_grant_in       (cdb_grant_in)
    );

    // Reference result straight from the function table
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b2, input logic [31:0] imm,
                                               input logic [31:0] pc);
        logic [31:0] b;
        logic [63:0] prod;
        b = op[4] ? imm : b2;
        prod = {32'd0, a} * {32'd0, b};
        case (op[3:0])
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return 32'($signed(a) >>> b[4:0]);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return imm;
            4'd11: return pc + imm;
            4'd12: return pc + 32'd4;
            4'd13: return MulEn ? prod[31:0] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observe the upcoming edge at the falling edge, then advance to just past it
    task automatic step();
        exp_t e;
        @(negedge clk_in);
        if (!rst_in || clr_in) begin
            q.delete();
        end else if (rdy_in) begin
            if (cdb_grant_in && alu_to_rs_ready) begin
                if (q.size() == 0) begin
                    check("pop_has_pending", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("cdb_result", alu_to_rs_result, e.result);
                    check("cdb_rob", 32'(alu_to_rs_rob_index), 32'(e.rob));
                end
            end
            if (rs_to_alu_ready && !alu_full_out) begin
                e.result = ref_result(rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
                                      rs_to_alu_imm, rs_to_alu_PC);
                e.rob = rs_to_alu_rob_index;
                q.push_back(e);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [RW-1:0] rob);
        rs_to_alu_ready     = 1'b1;
        rs_to_alu_op        = op;
        rs_to_alu_rs1       = a;
        rs_to_alu_rs2       = b;
        rs_to_alu_imm       = imm;
        rs_to_alu_PC        = pc;
        rs_to_alu_rob_index = rob;
    endtask

    // One op into an empty unit with grant held; checks exact result latency
    task automatic single_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [RW-1:0] rob,
                             input logic [31:0] exp, input int lat);
        drive_op(op, a, b, imm, pc, rob);
        step();
        rs_to_alu_ready = 1'b0;
        check({tag, "_ready_e0"}, 32'(alu_to_rs_ready), 32'd0);
        for (int i = 0; i < lat - 2; i++) begin
            check({tag, "_busy_full"}, 32'(alu_full_out), 32'd1);
            step();
            check({tag, "_ready_wait"}, 32'(alu_to_rs_ready), 32'd0);
        end
        if (lat > 2) check({tag, "_busy_full"}, 32'(alu_full_out), 32'd1);
        step();
        check({tag, "_ready"}, 32'(alu_to_rs_ready), 32'd1);
        check({tag, "_result"}, alu_to_rs_result, exp);
        check({tag, "_rob"}, 32'(alu_to_rs_rob_index), 32'(rob));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int guard;

        rst_in = 1'b0;
        rdy_in = 1'b1;
        clr_in = 1'b0;
        cdb_grant_in = 1'b1;
        drive_op(5'd0, 32'd1, 32'd2, 32'd3, 32'd4, 4'd5);

        // Reset holds every output at zero even with live traffic on the inputs
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready", 32'(alu_to_rs_ready), 32'd0);
        check("rst_result", alu_to_rs_result, 32'd0);
        check("rst_rob", 32'(alu_to_rs_rob_index), 32'd0);
        check("rst_full", 32'(alu_full_out), 32'd0);
        rs_to_alu_ready = 1'b0;
        rst_in = 1'b1;
        step();

        single_op("add", 5'd0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 2);

        // Back-to-back ops broadcast on consecutive cycles
        drive_op(5'd1, 32'd1, 32'd2, 32'd0, 32'd0, 4'd1);
        step();
        drive_op(5'h17, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 4'd2);
        step();
        check("b2b_sub", alu_to_rs_result, 32'hFFFF_FFFF);
        drive_op(5'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);
        step();
        rs_to_alu_ready = 1'b0;
        check("b2b_sra", alu_to_rs_result, 32'hF800_0000);
        step();
        check("b2b_sltu", alu_to_rs_result, 32'd1);
        check("b2b_sltu_ready", 32'(alu_to_rs_ready), 32'd1);
        step();
        check("b2b_empty", 32'(alu_to_rs_ready), 32'd0);

        // Backpressure: no grant, unit fills after DEPTH accepts
        cdb_grant_in = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive_op(5'd0, 32'(100 + acc), 32'd0, 32'd0, 32'd0, RW'(acc + 1));
            if (!alu_full_out) acc++;
            step();
        end
        check("bp_accepted", 32'(acc), 32'(DEPTH));
        check("bp_full", 32'(alu_full_out), 32'd1);
        check("bp_head_hold", alu_to_rs_result, 32'd100);
        cdb_grant_in = 1'b1;
        guard = 0;
        while (acc < 6 && guard < 30) begin
            drive_op(5'd0, 32'(100 + acc), 32'd0, 32'd0, 32'd0, RW'(acc + 1));
            if (!alu_full_out) acc++;
            step();
            guard++;
        end
        check("bp_all_accepted", 32'(acc), 32'd6);
        rs_to_alu_ready = 1'b0;
        guard = 0;
        while ((q.size() != 0 || alu_to_rs_ready) && guard < 30) begin
            step();
            guard++;
        end
        check("bp_drained", 32'(q.size()), 32'd0);

        // Flush with a dispatch and a grant on the same edge
        cdb_grant_in = 1'b0;
        drive_op(5'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        step();
        drive_op(5'd0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
        step();
        rs_to_alu_ready = 1'b0;
        step();
        check("clr_pre_ready", 32'(alu_to_rs_ready), 32'd1);
        drive_op(5'd0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd9);
        cdb_grant_in = 1'b1;
        clr_in = 1'b1;
        step();
        clr_in = 1'b0;
        rs_to_alu_ready = 1'b0;
        check("clr_ready", 32'(alu_to_rs_ready), 32'd0);
        check("clr_full", 32'(alu_full_out), 32'd0);
        check("clr_result", alu_to_rs_result, 32'd0);
        repeat (2) step();
        check("clr_no_exec", 32'(alu_to_rs_ready), 32'd0);

        single_op("auipc", 5'd11, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd4, 32'h3000, 2);
        single_op("link", 5'd12, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 4'd5, 32'd0, 2);
        single_op("mul", 5'd13, 32'h1_0000, 32'h1_0001, 32'd0, 32'd0, 4'd6,
                  MulEn ? 32'h1_0000 : 32'd0, MulEn ? 5 : 2);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 49) == 0);
            cdb_grant_in = ($urandom_range(0, 9) < 6);
            drive_op(5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     $urandom, $urandom, $urandom, RW'($urandom_range(1, 15)));
            rs_to_alu_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Asynchronous reset in the middle of a cycle drops in-flight work
        rdy_in = 1'b1;
        clr_in = 1'b0;
        cdb_grant_in = 1'b0;
        drive_op(5'd0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd7);
        repeat (3) step();
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_ready", 32'(alu_to_rs_ready), 32'd0);
        check("arst_full", 32'(alu_full_out), 32'd0);
        check("arst_result", alu_to_rs_result, 32'd0);
        step();
        rst_in = 1'b1;

        // Final drain: everything accepted must come out, nothing extra
        rs_to_alu_ready = 1'b0;
        cdb_grant_in = 1'b1;
        drive_op(5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 4'd8);
        step();
        rs_to_alu_ready = 1'b0;
        guard = 0;
        while ((q.size() != 0 || alu_to_rs_ready) && guard < 40) begin
            step();
            guard++;
        end
        check("final_q_empty", 32'(q.size()), 32'd0);
        check("final_ready", 32'(alu_to_rs_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
